// File: rtl/mpu_capture_pkg.sv
// ---------------------------------------------------------------------------
// mpu_capture_pkg
// Shared definitions for the MPU capture path: the capture FSM state type,
// the raw-to-physical scale constants and the default parameter values used
// by mpu_capture and the per-axis scaling blocks.
// ---------------------------------------------------------------------------
package mpu_capture_pkg;

    // Capture FSM states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_WAIT_RDY = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    // 1 g = 16384 LSB at +/-2 g; 1 g = 9.81 m/s^2 -> 981 in units of x100.
    localparam int SCALE_X100  = 981;
    localparam int SCALE_SHIFT = 14;

    // Baseline tracker: exponential average with weight 1/16.
    localparam int BL_SHIFT = 4;

    // Default parameter values.
    localparam int DEF_DECIM      = 4;
    localparam int DEF_MOV_THRESH = 150;
    localparam int DEF_MOV_ON     = 3;
    localparam int DEF_N_SAMPLES  = 30;
    localparam int DEF_COOLDOWN   = 1000;
    localparam int DEF_TIMEOUT    = 65535;

endpackage

// File: rtl/mpu_scale.sv
// ---------------------------------------------------------------------------
// mpu_scale
// Pure combinational conversion of one raw accelerometer axis sample
// (+/-2 g, 16384 LSB = 1 g) into m/s^2 x100, floor-rounded.
//
// Ports
//   raw   in  16 signed  raw axis sample
//   x100  out 32 signed  (raw * 981) >>> 14, sign-extended
// ---------------------------------------------------------------------------
module mpu_scale
    import mpu_capture_pkg::*;
(
    input  logic signed [15:0] raw,
    output logic signed [31:0] x100
);

    // |raw| <= 32768, so |raw * 981| < 2^25: a 26-bit signed product is exact.
    logic signed [25:0] product;

    always_comb begin
        product = 26'(raw) * 26'(SCALE_X100);
        // Arithmetic shift gives floor rounding, so -1 LSB maps to -1, not 0.
        x100    = 32'(product >>> SCALE_SHIFT);
    end

endmodule

// File: rtl/mpu_capture.sv
// ---------------------------------------------------------------------------
// mpu_capture
// Decimates the raw X-axis accelerometer stream, scales it to m/s^2 x100,
// tracks a slow baseline and opens a capture window of N_SAMPLES samples once
// MOV_ON consecutive decimated samples deviate from the baseline by more than
// MOV_THRESH. After the window it waits for the downstream classifier
// (result_ready, bounded by TIMEOUT cycles) and then holds off for COOLDOWN
// cycles before re-arming.
//
// Ports
//   clk           in   clock, all state changes on the rising edge
//   reset_n       in   asynchronous active-low reset
//   raw_valid     in   raw_x valid this cycle
//   raw_x         in   16 signed raw sample
//   result_ready  in   downstream classifier done with the window
//   mpu_valor     out  32 signed scaled sample, holds when mpu_valid=0
//   mpu_valid     out  single-cycle strobe for mpu_valor
//   mov           out  high for the whole capture window (CAPTURE, WAIT_RDY)
//   capture_err   out  single-cycle pulse on a result_ready timeout
// ---------------------------------------------------------------------------
module mpu_capture
    import mpu_capture_pkg::*;
#(
    parameter int DECIM      = DEF_DECIM,
    parameter int MOV_THRESH = DEF_MOV_THRESH,
    parameter int MOV_ON     = DEF_MOV_ON,
    parameter int N_SAMPLES  = DEF_N_SAMPLES,
    parameter int COOLDOWN   = DEF_COOLDOWN,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               raw_valid,
    input  logic signed [15:0] raw_x,
    input  logic               result_ready,
    output logic signed [31:0] mpu_valor,
    output logic               mpu_valid,
    output logic               mov,
    output logic               capture_err
);

    localparam int DEC_W  = $clog2(DECIM + 1);
    localparam int HIT_W  = $clog2(MOV_ON + 1);
    localparam int SMP_W  = $clog2(N_SAMPLES + 1);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int CD_W   = $clog2(COOLDOWN + 1);

    localparam logic signed [31:0] THRESH = 32'(MOV_THRESH);

    // -----------------------------------------------------------------------
    // Decimation: free-running in every FSM state so the accepted phase never
    // drifts relative to the sensor stream.
    // -----------------------------------------------------------------------
    logic [DEC_W-1:0] dec_cnt;
    logic             accept;

    assign accept = raw_valid && (dec_cnt == '0);

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dec_cnt <= '0;
        end else if (raw_valid) begin
            dec_cnt <= (dec_cnt == DEC_W'(DECIM - 1)) ? '0 : dec_cnt + DEC_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: scale and register the accepted sample.
    // -----------------------------------------------------------------------
    logic signed [31:0] x_scaled;
    logic signed [31:0] x_q;
    logic               x_vld;

    mpu_scale u_scale (
        .raw  (raw_x),
        .x100 (x_scaled)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q   <= '0;
            x_vld <= 1'b0;
        end else begin
            x_vld <= accept;
            if (accept) begin
                x_q <= x_scaled;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Motion detector datapath.
    // -----------------------------------------------------------------------
    logic signed [31:0] baseline;
    logic signed [31:0] diff;
    logic signed [31:0] abs_diff;
    logic signed [31:0] bl_step;
    logic               over;

    always_comb begin
        diff     = x_q - baseline;
        abs_diff = diff[31] ? -diff : diff;
        // Strictly greater: a deviation equal to the threshold is not motion.
        over     = abs_diff > THRESH;
        bl_step  = diff >>> BL_SHIFT;
    end

    // -----------------------------------------------------------------------
    // Capture FSM.
    // -----------------------------------------------------------------------
    state_t             state,     state_nxt;
    logic [HIT_W-1:0]   hit_cnt,   hit_nxt;
    logic [SMP_W-1:0]   smp_cnt,   smp_nxt;
    logic [WAIT_W-1:0]  wait_cnt,  wait_nxt;
    logic [CD_W-1:0]    cd_cnt,    cd_nxt;
    logic signed [31:0] baseline_nxt;
    logic               bl_loaded, bl_loaded_nxt;
    logic signed [31:0] valor_nxt;
    logic               valid_nxt;
    logic               err_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            hit_cnt     <= '0;
            smp_cnt     <= '0;
            wait_cnt    <= '0;
            cd_cnt      <= '0;
            baseline    <= '0;
            bl_loaded   <= 1'b0;
            mpu_valor   <= '0;
            mpu_valid   <= 1'b0;
            capture_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            hit_cnt     <= hit_nxt;
            smp_cnt     <= smp_nxt;
            wait_cnt    <= wait_nxt;
            cd_cnt      <= cd_nxt;
            baseline    <= baseline_nxt;
            bl_loaded   <= bl_loaded_nxt;
            mpu_valor   <= valor_nxt;
            mpu_valid   <= valid_nxt;
            capture_err <= err_nxt;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        hit_nxt       = hit_cnt;
        smp_nxt       = smp_cnt;
        wait_nxt      = wait_cnt;
        cd_nxt        = cd_cnt;
        baseline_nxt  = baseline;
        bl_loaded_nxt = bl_loaded;
        valor_nxt     = mpu_valor;
        valid_nxt     = 1'b0;
        err_nxt       = 1'b0;

        unique case (state)
            ST_IDLE, ST_ARMED: begin
                if (x_vld) begin
                    if (!bl_loaded) begin
                        // First sample after reset only seeds the baseline.
                        baseline_nxt  = x_q;
                        bl_loaded_nxt = 1'b1;
                    end else if (over) begin
                        if (hit_cnt == HIT_W'(MOV_ON - 1)) begin
                            // This hit completes the run: it is sample 0.
                            hit_nxt   = '0;
                            valid_nxt = 1'b1;
                            valor_nxt = x_q;
                            smp_nxt   = SMP_W'(1);
                            wait_nxt  = '0;
                            state_nxt = (N_SAMPLES == 1) ? ST_WAIT_RDY : ST_CAPTURE;
                        end else begin
                            hit_nxt   = hit_cnt + HIT_W'(1);
                            state_nxt = ST_ARMED;
                        end
                    end else begin
                        hit_nxt   = '0;
                        state_nxt = ST_IDLE;
                        // An aborted run must not drag the baseline toward the
                        // motion, so only a quiet IDLE sample updates it.
                        if (state == ST_IDLE) begin
                            baseline_nxt = baseline + bl_step;
                        end
                    end
                end
            end

            ST_CAPTURE: begin
                if (x_vld) begin
                    valid_nxt = 1'b1;
                    valor_nxt = x_q;
                    if (smp_cnt == SMP_W'(N_SAMPLES - 1)) begin
                        smp_nxt   = '0;
                        wait_nxt  = '0;
                        state_nxt = ST_WAIT_RDY;
                    end else begin
                        smp_nxt = smp_cnt + SMP_W'(1);
                    end
                end
            end

            ST_WAIT_RDY: begin
                // result_ready has priority over a coincident timeout.
                if (result_ready) begin
                    wait_nxt  = '0;
                    cd_nxt    = '0;
                    state_nxt = ST_COOLDOWN;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    wait_nxt  = '0;
                    cd_nxt    = '0;
                    err_nxt   = 1'b1;
                    state_nxt = ST_COOLDOWN;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end

            ST_COOLDOWN: begin
                // Samples are dropped and the baseline is frozen here.
                if (cd_cnt == CD_W'(COOLDOWN - 1)) begin
                    cd_nxt    = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cd_nxt = cd_cnt + CD_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Decoded straight from the state register so reset clears it at once.
    assign mov = (state == ST_CAPTURE) || (state == ST_WAIT_RDY);

endmodule

// File: tb/tb_mpu_capture.sv
// ---------------------------------------------------------------------------
// tb_mpu_capture
// Self-checking bench for mpu_capture. Expected samples are queued when the
// stimulus is driven and compared as mpu_valid strobes come out.
// ---------------------------------------------------------------------------
module tb_mpu_capture;

    localparam int DECIM      = 4;
    localparam int MOV_THRESH = 150;
    localparam int MOV_ON     = 3;
    localparam int N_SAMPLES  = 30;
    localparam int CD         = 20;
    localparam int TO         = 16;

    localparam int FILLER = 16'sh7000;

    logic               clk;
    logic               reset_n;
    logic               raw_valid;
    logic signed [15:0] raw_x;
    logic               result_ready;
    logic signed [31:0] mpu_valor;
    logic               mpu_valid;
    logic               mov;
    logic               capture_err;

    mpu_capture #(
        .DECIM      (DECIM),
        .MOV_THRESH (MOV_THRESH),
        .MOV_ON     (MOV_ON),
        .N_SAMPLES  (N_SAMPLES),
        .COOLDOWN   (CD),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_valid    (raw_valid),
        .raw_x        (raw_x),
        .result_ready (result_ready),
        .mpu_valor    (mpu_valor),
        .mpu_valid    (mpu_valid),
        .mov          (mov),
        .capture_err  (capture_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int exp_q[$];
    int last_push;
    int acc_cyc;
    int mov_rise_cyc   = -1;
    int first_valid_cyc = -1;
    int last_valid_cyc = -1;
    int cap_valids     = 0;
    int rises          = 0;
    int errs           = 0;
    int err_cyc        = -1;
    logic mov_q        = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Floor division written independently of the shift form.
    function automatic int exp_x(input int raw);
        int p;
        p = raw * 981;
        if (p >= 0) return p / 16384;
        return -((-p + 16383) / 16384);
    endfunction

    always @(posedge clk) cyc++;

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (mov && !mov_q) begin
            mov_rise_cyc = cyc;
            rises++;
            cap_valids = 0;
        end
        if (mpu_valid) begin
            check("valid_with_mov", int'(mov), 1);
            if (cap_valids == 0) first_valid_cyc = cyc;
            cap_valids++;
            last_valid_cyc = cyc;
            check("sb_pending", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("valor", mpu_valor, exp_q.pop_front());
        end
        if (capture_err) begin
            err_cyc = cyc;
            errs++;
        end
        mov_q = mov;
    end

    // One decimation group: accepted sample first, then ignored fillers.
    task automatic send_group(input int raw, input bit push);
        acc_cyc   = cyc;
        raw_valid = 1'b1;
        raw_x     = 16'(raw);
        if (push) begin
            last_push = exp_x(raw);
            exp_q.push_back(last_push);
        end
        @(posedge clk); #1;
        for (int i = 1; i < DECIM; i++) begin
            raw_x = 16'(FILLER);
            @(posedge clk); #1;
        end
        raw_valid = 1'b0;
        raw_x     = '0;
    endtask

    task automatic wait_cyc(input int target);
        if (cyc > target) check("schedule_late", cyc, target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_trigger(input string tag);
        check({tag, "_latency"}, mov_rise_cyc - acc_cyc, 2);
        check({tag, "_valid_rise"}, first_valid_cyc, mov_rise_cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int r;
        int rises_before;
        reset_n      = 1'b0;
        raw_valid    = 1'b0;
        raw_x        = '0;
        result_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_mov",   int'(mov), 0);
        check("rst_valid", int'(mpu_valid), 0);
        check("rst_err",   int'(capture_err), 0);
        check("rst_valor", mpu_valor, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // False starts: two hits then x=100, two hits then x=150 (boundary).
        send_group(0, 0);
        send_group(4096, 0);
        send_group(4096, 0);
        send_group(1671, 0);
        send_group(4096, 0);
        send_group(4096, 0);
        send_group(2506, 0);
        repeat (4) @(posedge clk);
        #1;
        check("fs_no_rise", rises, 0);
        check("fs_mov_low", int'(mov), 0);

        // Baseline tracking with floor shift: 0 -> 9 -> -1, then x=150 is a hit.
        send_group(2506, 0);
        send_group(-2354, 0);
        send_group(2506, 0);
        send_group(4096, 0);
        send_group(4096, 1);
        check_trigger("trig1");
        send_group(16384, 1);
        send_group(-16384, 1);
        send_group(1, 1);
        send_group(-1, 1);
        for (int i = 5; i < N_SAMPLES; i++) send_group(i * 1237 - 18000, 1);

        // Handshake 5 cycles into WAIT_RDY.
        w = last_valid_cyc;
        wait_cyc(w + 5);
        check("wait_mov_high", int'(mov), 1);
        check("wait_count", cap_valids, N_SAMPLES);
        check("wait_valor_hold", mpu_valor, last_push);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        r = cyc;
        check("rdy_mov_low", int'(mov), 0);
        check("rdy_no_err", errs, 0);

        // Sample landing in the last COOLDOWN cycle is ignored; three more trigger.
        wait_cyc(r + CD - 2);
        send_group(4096, 0);
        send_group(4096, 0);
        send_group(4096, 0);
        check("cd_end_rises", rises, 1);
        send_group(4096, 1);
        check_trigger("trig2");
        check("cd_end_rises2", rises, 2);

        // Abort mid-capture with reset after sample 12.
        for (int i = 1; i <= 12; i++) send_group(3000 - i * 911, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_mov",   int'(mov), 0);
        check("abort_valid", int'(mpu_valid), 0);
        check("abort_err",   int'(capture_err), 0);
        check("abort_valor", mpu_valor, 0);
        check("abort_count", cap_valids, 13);
        check("abort_sb_empty", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Fresh capture: baseline 0, three accepted x=245 samples.
        rises_before = rises;
        send_group(0, 0);
        send_group(4096, 0);
        send_group(4096, 0);
        check("fresh_two_hits", rises, rises_before);
        send_group(4096, 1);
        check_trigger("trig3");
        for (int i = 1; i < N_SAMPLES; i++) send_group((i * 2711) % 32000 - 16000, 1);

        // Timeout with result_ready held low.
        w = last_valid_cyc;
        wait_cyc(w + TO - 1);
        check("to_count", cap_valids, N_SAMPLES);
        check("to_mov_high", int'(mov), 1);
        check("to_no_err_yet", errs, 0);
        wait_cyc(w + TO + 2);
        check("to_err_cycle", err_cyc, w + TO);
        check("to_err_once", errs, 1);
        check("to_mov_low", int'(mov), 0);

        // First IDLE cycle after COOLDOWN already counts as a hit.
        r = w + TO;
        wait_cyc(r + CD - 1);
        send_group(4096, 0);
        send_group(4096, 0);
        send_group(4096, 1);
        check_trigger("trig4");
        check("final_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mpu_capture.md
MPU_CAPTURE -- requirements
Module: mpu_capture

Interface
REQ-001 Parameter DECIM, default 4: accept one of every DECIM raw samples.
REQ-002 Parameter MOV_THRESH, default 150: motion threshold on |x - baseline|, m/s^2 x100.
REQ-003 Parameter MOV_ON, default 3: number of consecutive over-threshold decimated samples that triggers a capture.
REQ-004 Parameter N_SAMPLES, default 30: samples emitted per capture.
REQ-005 Parameter COOLDOWN, default 1000: clk cycles with mov low after each capture; minimum 1.
REQ-006 Parameter TIMEOUT, default 65535: maximum clk cycles spent waiting for result_ready.
REQ-007 Port clk, input, 1: the block's single clock; all state changes on its rising edge.
REQ-008 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-009 Port raw_valid, input, 1: raw_x is valid this cycle (single-cycle strobe).
REQ-010 Port raw_x, input, 16, signed: raw X-axis accelerometer sample at +/-2 g (16384 LSB = 1 g).
REQ-011 Port result_ready, input, 1: ready flag from the downstream gesture classifier.
REQ-012 Port mpu_valor, output, 32, signed: scaled sample in m/s^2 x100.
REQ-013 Port mpu_valid, output, 1: single-cycle strobe marking mpu_valor valid.
REQ-014 Port mov, output, 1: motion window flag; high for the whole capture.
REQ-015 Port capture_err, output, 1: single-cycle pulse on a result_ready timeout.

Function
REQ-016 Decimation: a modulo-DECIM counter advances on every raw_valid; only count-0 samples are accepted; the counter keeps running in every state.
REQ-017 Scaling: x = (raw_x * 981) >>> 14, arithmetic shift (floor), sign-extended to 32 bits; the 26-bit product never overflows.
REQ-018 Stage 1 registers x one cycle after an accepted raw_valid; the FSM acts on it the next cycle, so mpu_valid follows an accepted raw_valid by exactly 2 cycles.
REQ-019 Baseline: the first accepted sample after reset loads baseline = x; afterwards, in IDLE only, baseline += (x - baseline) >>> 4.
REQ-020 States: IDLE, ARMED, CAPTURE, WAIT_RDY, COOLDOWN.
REQ-021 IDLE: if |x - baseline| > MOV_THRESH, go to ARMED with hit count 1; otherwise update the baseline.
REQ-022 ARMED: over-threshold sample increments the hit count; under-threshold returns to IDLE, clears the count, and leaves the baseline unchanged.
REQ-023 The sample that brings the hit count to MOV_ON is sample 0; in that same cycle mpu_valid=1 and mov rises; go to CAPTURE.
REQ-024 CAPTURE: each accepted sample emits mpu_valid with mov=1; after sample N_SAMPLES-1, go to WAIT_RDY.
REQ-025 WAIT_RDY: hold mov=1 and emit no mpu_valid; result_ready=1 or TIMEOUT cycles elapsed goes to COOLDOWN; a timeout also pulses capture_err.
REQ-026 COOLDOWN: mov=0 for COOLDOWN cycles, then go to IDLE; samples are ignored and the baseline is frozen.
REQ-027 Threshold boundary: |x - baseline| equal to MOV_THRESH does not count as a hit.
REQ-028 result_ready and a timeout in the same cycle count as result_ready; capture_err stays 0.
REQ-029 mpu_valid is never asserted while mov=0; mpu_valor holds its last value when mpu_valid=0.

Reset
REQ-030 While reset_n=0: state=IDLE; mov, mpu_valid, capture_err and mpu_valor = 0; all counters 0; the baseline-loaded flag is cleared.
REQ-031 Reset in mid-capture aborts the capture; mov drops asynchronously so the downstream buffer clears.

Structure
REQ-032 A shared package holds the FSM state enum, the 981 scale constant and the default parameter values.
REQ-033 One sub-module, mpu_scale: pure combinational raw-to-x100 conversion, reused by the other MPU axes.

Verification
REQ-034 Scaling: raw_x = 16384, -16384, 1, -1 -> mpu_valor = 981, -981, 0, -1.
REQ-035 Trigger: baseline 0; three accepted samples of raw_x=4096 (x=245) -> mov and mpu_valid rise together 2 cycles after the 3rd accepted raw_valid; exactly 30 mpu_valid pulses follow.
REQ-036 False start: two over-threshold samples, then x=100 -> back to IDLE, mov stays 0, hit count 0.
REQ-037 Handshake: result_ready asserted 5 cycles into WAIT_RDY -> mov low the next cycle for exactly COOLDOWN cycles, then back to IDLE.
REQ-038 Timeout: TIMEOUT=16, result_ready held 0 -> one capture_err pulse at cycle 16, then COOLDOWN.
REQ-039 Reset: reset_n pulled low during sample 12 -> all outputs 0 immediately; the next capture still requires MOV_ON fresh hits.
